// File: rtl/router_1xn_param_pkg.sv
// Shared types and helpers for the 1xN packet router: FSM states and header field extraction.
package router_1xn_param_pkg;

  localparam int HDR_MAX_W = 32;

  typedef enum logic [2:0] {
    ST_DECODE,
    ST_WAIT_EMPTY,
    ST_LOAD_DATA,
    ST_CHECK,
    ST_DROP
  } state_e;

  function automatic logic [HDR_MAX_W-1:0] hdr_addr(input logic [HDR_MAX_W-1:0] hdr,
                                                    input int unsigned aw);
    return hdr & ((HDR_MAX_W'(1) << aw) - HDR_MAX_W'(1));
  endfunction

  function automatic logic [HDR_MAX_W-1:0] hdr_len(input logic [HDR_MAX_W-1:0] hdr,
                                                   input int unsigned aw,
                                                   input int unsigned dw);
    return (hdr >> aw) & ((HDR_MAX_W'(1) << (dw - aw)) - HDR_MAX_W'(1));
  endfunction

endpackage

// File: rtl/router_1xn_param_fifo_ch.sv
// One output channel: synchronous FIFO with registered read data, plus an unread-timeout
// counter that flushes the whole FIFO when the consumer ignores it for TIMEOUT cycles.
module router_1xn_param_fifo_ch #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rd,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_empty,
  output logic              o_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW:0]       r_wp, r_rp;
  logic [TW-1:0]     r_tcnt;
  logic              w_empty, w_full, w_rd, w_wr, w_flush;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[PW] != r_rp[PW]) && (r_wp[PW-1:0] == r_rp[PW-1:0]);
  assign w_rd    = i_rd && !w_empty;
  assign w_wr    = i_wr && (!w_full || w_rd);
  // Flush wins over a same-cycle write; a flush never coincides with a read.
  assign w_flush = !w_empty && !i_rd && (r_tcnt == TW'(TIMEOUT - 1));

  assign o_empty = w_empty;
  assign o_full  = w_full;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (w_flush) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !w_flush) r_mem[r_wp[PW-1:0]] <= i_wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   o_rdata <= '0;
    else if (w_rd) o_rdata <= r_mem[r_rp[PW-1:0]];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                          r_tcnt <= '0;
    else if (w_empty || i_rd || w_flush)  r_tcnt <= '0;
    else                                  r_tcnt <= r_tcnt + 1'b1;
  end

endmodule

// File: rtl/router_1xn_param.sv
// 1xN byte-packet router: input FSM with parity check, address decode and write demux
// into NUM_CH per-channel FIFOs; packets to nonexistent channels are consumed and dropped.
module router_1xn_param
  import router_1xn_param_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 3,
  parameter int ADDR_W     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     packet_valid,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [NUM_CH-1:0]        read_enb,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        vldout,
  output logic                     busy,
  output logic                     err,
  output logic                     drop
);

  state_e                         r_state, w_nstate;
  logic [DATA_W-1:0]              r_hdr, r_par, r_rxpar, w_wdata;
  logic [ADDR_W-1:0]              r_dest, w_addr, w_sel;
  logic                           r_err, r_drop;
  logic                           w_busy, w_we, w_addr_ok, w_sel_empty, w_sel_full;
  logic [NUM_CH-1:0]              w_empty, w_full, w_wr;
  logic [NUM_CH-1:0][DATA_W-1:0]  w_rdata;

  assign w_addr    = ADDR_W'(hdr_addr(HDR_MAX_W'(data_in), ADDR_W));
  assign w_addr_ok = (32'(w_addr) < 32'(NUM_CH));
  // In DECODE the destination is the incoming header; afterwards it is the latched one.
  assign w_sel     = (r_state == ST_DECODE) ? w_addr : r_dest;

  always_comb begin
    w_sel_empty = 1'b0;
    w_sel_full  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_sel == ADDR_W'(i)) begin
        w_sel_empty = w_empty[i];
        w_sel_full  = w_full[i];
      end
    end
  end

  always_comb begin
    case (r_state)
      ST_WAIT_EMPTY, ST_CHECK: w_busy = 1'b1;
      ST_LOAD_DATA:            w_busy = w_sel_full;
      default:                 w_busy = 1'b0;
    endcase
  end

  always_comb begin
    w_nstate = r_state;
    w_we     = 1'b0;
    w_wdata  = data_in;
    case (r_state)
      ST_DECODE: begin
        if (packet_valid) begin
          if (!w_addr_ok) begin
            w_nstate = ST_DROP;
          end else if (w_sel_empty) begin
            w_we     = 1'b1;
            w_nstate = ST_LOAD_DATA;
          end else begin
            w_nstate = ST_WAIT_EMPTY;
          end
        end
      end
      ST_WAIT_EMPTY: begin
        w_wdata = r_hdr;
        if (w_sel_empty) begin
          w_we     = 1'b1;
          w_nstate = ST_LOAD_DATA;
        end
      end
      ST_LOAD_DATA: begin
        if (!w_sel_full) begin
          w_we = 1'b1;
          if (!packet_valid) w_nstate = ST_CHECK;
        end
      end
      ST_CHECK: w_nstate = ST_DECODE;
      ST_DROP:  if (!packet_valid) w_nstate = ST_DECODE;
      default:  w_nstate = ST_DECODE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_DECODE;
      r_hdr   <= '0;
      r_dest  <= '0;
      r_par   <= '0;
      r_rxpar <= '0;
      r_err   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_drop  <= (r_state == ST_DROP) && !packet_valid;
      case (r_state)
        ST_DECODE: begin
          if (packet_valid) begin
            r_hdr  <= data_in;
            r_dest <= w_addr;
            r_par  <= data_in;
            r_err  <= 1'b0;
          end
        end
        ST_LOAD_DATA: begin
          if (!w_sel_full) begin
            if (packet_valid) r_par   <= r_par ^ data_in;
            else              r_rxpar <= data_in;
          end
        end
        ST_CHECK: r_err <= (r_par != r_rxpar);
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_wr[g] = w_we && (w_sel == ADDR_W'(g));

    router_1xn_param_fifo_ch #(
      .DATA_W  (DATA_W),
      .DEPTH   (FIFO_DEPTH),
      .TIMEOUT (TIMEOUT)
    ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_wr    (w_wr[g]),
      .i_wdata (w_wdata),
      .i_rd    (read_enb[g]),
      .o_rdata (w_rdata[g]),
      .o_empty (w_empty[g]),
      .o_full  (w_full[g])
    );

    assign data_out[g*DATA_W +: DATA_W] = w_rdata[g];
    assign vldout[g]                    = !w_empty[g];
  end

  assign busy = w_busy;
  assign err  = r_err;
  assign drop = r_drop;

endmodule

// File: tb/tb_router_1xn_param.sv
// Scoreboard bench for the 1xN router: bytes are queued per channel as they are driven
// and checked as each read returns data; scenario tasks check control outputs inline.
module tb_router_1xn_param;

  localparam int DW = 8;
  localparam int NC = 3;

  logic             clk = 1'b0;
  logic             resetn;
  logic             packet_valid;
  logic [DW-1:0]    data_in;
  logic [NC-1:0]    read_enb;
  logic [NC*DW-1:0] data_out;
  logic [NC-1:0]    vldout;
  logic             busy, err, drop;

  router_1xn_param dut (
    .clk          (clk),
    .resetn       (resetn),
    .packet_valid (packet_valid),
    .data_in      (data_in),
    .read_enb     (read_enb),
    .data_out     (data_out),
    .vldout       (vldout),
    .busy         (busy),
    .err          (err),
    .drop         (drop)
  );

  always #5 clk = ~clk;

  logic [7:0] sb [NC][$];
  int n_cmp = 0, n_bad = 0, n_sent = 0;
  int n_rx [NC];
  int n_drop = 0, n_busy = 0;
  logic [NC-1:0] mon_pend;
  logic [7:0]    mon_exp;

  initial for (int i = 0; i < NC; i++) n_rx[i] = 0;

  // Read data appears one edge after a read of a non-empty FIFO.
  always begin
    @(posedge clk);
    mon_pend = read_enb & vldout;
    #1;
    for (int i = 0; i < NC; i++) begin
      if (mon_pend[i]) begin
        n_cmp++;
        n_rx[i]++;
        if (sb[i].size() == 0) begin
          n_bad++;
          $display("FAIL rd_unexpected ch%0d: got %h, expected no data", i, data_out[i*DW +: DW]);
        end else begin
          mon_exp = sb[i].pop_front();
          if (data_out[i*DW +: DW] !== mon_exp) begin
            n_bad++;
            $display("FAIL rd_data ch%0d: got %h, expected %h", i, data_out[i*DW +: DW], mon_exp);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (drop === 1'b1) n_drop++;
    if (busy === 1'b1) n_busy++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic put_byte(input logic pv, input logic [7:0] b, output int w);
    packet_valid = pv;
    data_in      = b;
    w            = 0;
    while (busy === 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL put_byte_stall: busy stuck 1 for %0d cycles, expected release", w);
    end
    n_sent++;
    @(negedge clk);
  endtask

  task automatic send_pkt(input int addr, input int len, input bit bad_par, input bit push,
                          output int hw);
    logic [7:0] hdr, par, b;
    int w;
    hdr = 8'((len << 2) | addr);
    par = hdr;
    if (push) sb[addr].push_back(hdr);
    put_byte(1'b1, hdr, hw);
    for (int k = 0; k < len; k++) begin
      b   = 8'($urandom_range(0, 255));
      par = par ^ b;
      if (push) sb[addr].push_back(b);
      put_byte(1'b1, b, w);
    end
    if (bad_par) par = par ^ 8'h01;
    if (push) sb[addr].push_back(par);
    put_byte(1'b0, par, w);
  endtask

  task automatic drain(input int ch);
    int t = 0;
    while ((sb[ch].size() != 0 || vldout[ch] === 1'b1) && t < 200) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; packet_valid = 1'b0; data_in = '0; read_enb = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({data_out, vldout, busy, err, drop} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h, expected 0", {data_out, vldout, busy, err, drop});
    end
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({vldout, busy, err, drop} !== '0) begin
      n_bad++;
      $display("FAIL post_reset_idle: got %h, expected 0", {vldout, busy, err, drop});
    end
  endtask

  task automatic test_route();
    int hw, rx0;
    rx0 = n_rx[1];
    read_enb[1] = 1'b1;
    send_pkt(1, 14, 1'b0, 1'b1, hw);
    drain(1);
    read_enb[1] = 1'b0;
    n_cmp++;
    if (n_rx[1] - rx0 !== 16) begin
      n_bad++;
      $display("FAIL route_count: got %0d bytes, expected 16", n_rx[1] - rx0);
    end
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL route_err: got %b, expected 0", err);
    end
  endtask

  task automatic test_parity_err();
    int hw;
    read_enb[1] = 1'b1;
    send_pkt(1, 14, 1'b1, 1'b1, hw);
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL parity_err_set: got %b, expected 1", err);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL parity_err_hold: got %b, expected 1", err);
    end
    fork
      send_pkt(1, 4, 1'b1, 1'b1, hw);
      begin
        @(posedge clk);
        #2;
        n_cmp++;
        if (err !== 1'b0) begin
          n_bad++;
          $display("FAIL parity_err_clear_at_hdr: got %b, expected 0", err);
        end
      end
    join
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL parity_err_second: got %b, expected 1", err);
    end
    drain(1);
    read_enb[1] = 1'b0;
    n_cmp++;
    if (sb[1].size() !== 0) begin
      n_bad++;
      $display("FAIL parity_drain: got %0d left, expected 0", sb[1].size());
    end
  endtask

  task automatic test_drop();
    int hw, d0, b0;
    d0 = n_drop;
    b0 = n_busy;
    send_pkt(3, 5, 1'b0, 1'b0, hw);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (n_drop - d0 !== 1) begin
      n_bad++;
      $display("FAIL drop_pulse: got %0d pulses, expected 1", n_drop - d0);
    end
    n_cmp++;
    if (n_busy - b0 !== 0) begin
      n_bad++;
      $display("FAIL drop_busy: got %0d busy cycles, expected 0", n_busy - b0);
    end
    n_cmp++;
    if (vldout !== '0) begin
      n_bad++;
      $display("FAIL drop_vldout: got %b, expected 000", vldout);
    end
  endtask

  task automatic test_stall();
    int hw;
    n_sent = 0;
    read_enb[0] = 1'b0;
    fork
      send_pkt(0, 20, 1'b0, 1'b1, hw);
      begin
        int t = 0;
        do begin
          @(posedge clk);
          #2;
          t++;
        end while (busy !== 1'b1 && t < 100);
        n_cmp++;
        if (n_sent !== 16) begin
          n_bad++;
          $display("FAIL stall_busy_at: busy after %0d bytes, expected 16", n_sent);
        end
        @(negedge clk);
        read_enb[0] = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
          n_bad++;
          $display("FAIL stall_release: busy %b after 4 reads, expected 0", busy);
        end
      end
    join
    drain(0);
    read_enb[0] = 1'b0;
    n_cmp++;
    if (sb[0].size() !== 0 || n_sent !== 22) begin
      n_bad++;
      $display("FAIL stall_complete: %0d left, %0d sent, expected 0 left, 22 sent",
               sb[0].size(), n_sent);
    end
  endtask

  task automatic test_timeout();
    int hw, cnt, rx0;
    cnt = 0;
    fork
      send_pkt(2, 3, 1'b0, 1'b0, hw);
      begin
        int t = 0;
        while (vldout[2] !== 1'b1 && t < 100) begin
          @(negedge clk);
          t++;
        end
        while (vldout[2] === 1'b1 && cnt < 100) begin
          cnt++;
          @(negedge clk);
        end
      end
    join
    n_cmp++;
    if (cnt !== 30) begin
      n_bad++;
      $display("FAIL timeout_flush: vldout[2] high %0d cycles, expected 30", cnt);
    end
    rx0 = n_rx[2];
    read_enb[2] = 1'b1;
    send_pkt(2, 4, 1'b0, 1'b1, hw);
    drain(2);
    read_enb[2] = 1'b0;
    n_cmp++;
    if (n_rx[2] - rx0 !== 6 || sb[2].size() !== 0) begin
      n_bad++;
      $display("FAIL timeout_next_pkt: got %0d bytes, %0d left, expected 6 and 0",
               n_rx[2] - rx0, sb[2].size());
    end
  endtask

  task automatic test_back_to_back();
    int hw0, hw1;
    read_enb[0] = 1'b1;
    send_pkt(0, 3, 1'b0, 1'b1, hw0);
    send_pkt(0, 2, 1'b0, 1'b1, hw1);
    n_cmp++;
    if (hw0 !== 0 || hw1 !== 1) begin
      n_bad++;
      $display("FAIL b2b_hdr_wait: got %0d/%0d cycles, expected 0/1", hw0, hw1);
    end
    drain(0);
    read_enb[0] = 1'b0;
    n_cmp++;
    if (sb[0].size() !== 0) begin
      n_bad++;
      $display("FAIL b2b_drain: got %0d left, expected 0", sb[0].size());
    end
  endtask

  task automatic test_reset_mid();
    int w, hw, rx0;
    put_byte(1'b1, 8'((6 << 2) | 1), w);
    for (int k = 0; k < 3; k++) put_byte(1'b1, 8'(8'hA0 + k), w);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({data_out, vldout, busy, err, drop} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_async: got %h, expected 0", {data_out, vldout, busy, err, drop});
    end
    packet_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    rx0 = n_rx[1];
    read_enb[1] = 1'b1;
    send_pkt(1, 5, 1'b0, 1'b1, hw);
    drain(1);
    read_enb[1] = 1'b0;
    n_cmp++;
    if (n_rx[1] - rx0 !== 7 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_next_pkt: got %0d bytes err=%b, expected 7 bytes err=0",
               n_rx[1] - rx0, err);
    end
  endtask

  initial begin
    resetn = 1'b0; packet_valid = 1'b0; data_in = '0; read_enb = '0;
    @(negedge clk);
    test_reset();
    test_route();
    test_parity_err();
    test_drop();
    test_stall();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
